// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash streaming model.
//   state_t   : FSM state encoding for spi_flash_stream
//   CMD_*     : supported command opcodes
//   lat_of()  : cycles from the last address bit to the first data bit
package spi_flash_pkg;

  typedef enum logic [2:0] {CMD, ADDR, WAIT, DATA, ID, ERR} state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDID      = 8'h9F;

  // The backing store needs one cycle to be strobed and one to return data,
  // so the latency can never be shorter than 2 even with zero dummy cycles.
  function automatic logic [4:0] lat_of(input logic [7:0] cmd, input int unsigned dummy);
    if (cmd == CMD_FAST_READ && dummy > 2) return 5'(dummy);
    return 5'd2;
  endfunction

endpackage

// File: rtl/spi_flash_tx_shifter.sv
// Transmit shift register for the flash data phase.
//   spi_clk, reset : clock, async active-high reset
//   load           : capture rdata (byte-reordered, pre-shifted by load_offset bytes)
//   load_offset    : byte offset of the first byte to send from this word
//   shift          : shift one bit out (ignored while load is high)
//   rdata          : backing-store word, byte 0 in bits [7:0]
//   msb            : current serial output bit
//   near_end       : bit counter is two bits before the end of the word
module spi_flash_tx_shifter #(
  parameter int DATA_BYTES = 8,
  localparam int W = 8 * DATA_BYTES,
  localparam int OFF = $clog2(DATA_BYTES)
) (
  input  logic           spi_clk,
  input  logic           reset,
  input  logic           load,
  input  logic [OFF-1:0] load_offset,
  input  logic           shift,
  input  logic [W-1:0]   rdata,
  output logic           msb,
  output logic           near_end
);

  localparam int BW = OFF + 3;

  logic [W-1:0]  sr;
  logic [BW-1:0] b;
  logic [W-1:0]  reordered;

  // Byte 0 goes to the top so the lowest address is transmitted first.
  always_comb begin
    reordered = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      reordered[W-1-8*i -: 8] = rdata[8*i +: 8];
    end
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
      b  <= '0;
    end else if (load) begin
      sr <= reordered << {load_offset, 3'b000};
      b  <= {load_offset, 3'b000};
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
      b  <= b + 1'b1;
    end
  end

  assign msb      = sr[W-1];
  assign near_end = (b == BW'(W - 2));

endmodule

// File: rtl/spi_flash_stream.sv
// SPI NOR flash simulation model with streaming reads and one-word prefetch.
//   spi_clk, reset : SPI clock, async active-high reset (chip-select deassert)
//   spi_mosi       : serial command/address input, sampled on posedge
//   spi_miso       : serial data output
//   mem_ren        : one-cycle read strobe to the external backing store
//   mem_addr       : word-aligned byte address for mem_ren
//   mem_rdata      : backing-store word, valid the cycle after mem_ren
//   cmd_err        : one-cycle pulse on an unsupported opcode
//
// state | meaning
// CMD   | shifting in the 8-bit opcode
// ADDR  | shifting in the ADDR_BITS start address
// WAIT  | first word fetch and dummy/latency cycles
// DATA  | streaming bytes out, prefetching the next word
// ID    | repeating JEDEC_ID out
// ERR   | unsupported opcode, output held low until reset
module spi_flash_stream
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_BITS    = 24,
  parameter int          DATA_BYTES   = 8,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4017
) (
  input  logic                    spi_clk,
  input  logic                    reset,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    mem_ren,
  output logic [ADDR_BITS-1:0]    mem_addr,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    cmd_err
);

  localparam int OFF   = $clog2(DATA_BYTES);
  localparam int CNT_W = $clog2(ADDR_BITS + 32);
  localparam logic [ADDR_BITS-1:0] WORD_MASK = ~ADDR_BITS'(DATA_BYTES - 1);
  localparam logic [ADDR_BITS-1:0] STEP      = ADDR_BITS'(DATA_BYTES);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-2:0] addr_sr;
  logic [ADDR_BITS-1:0] word_addr;
  logic [OFF-1:0]       offset;
  logic [4:0]           lat;
  logic [23:0]          id_sr;
  logic                 ren_q;
  logic                 pf_pending;

  logic [7:0]           cmd_next;
  logic [ADDR_BITS-1:0] addr_next;
  logic                 prefetch;
  logic                 tx_load;
  logic [OFF-1:0]       tx_offset;
  logic                 tx_shift;
  logic                 tx_msb;
  logic                 near_end;

  assign cmd_next  = {cmd_sr, spi_mosi};
  assign addr_next = {addr_sr, spi_mosi};

  // Fetch the next word two bits early: strobe now, data back next cycle,
  // loaded on the edge that retires the last bit of the current word.
  assign prefetch  = (state == DATA) && near_end;

  assign tx_load   = ((state == WAIT) && (cnt == CNT_W'(2))) || ((state == DATA) && pf_pending);
  assign tx_offset = (state == WAIT) ? offset : '0;
  assign tx_shift  = (state == DATA);

  spi_flash_tx_shifter #(.DATA_BYTES(DATA_BYTES)) u_tx (
    .spi_clk     (spi_clk),
    .reset       (reset),
    .load        (tx_load),
    .load_offset (tx_offset),
    .shift       (tx_shift),
    .rdata       (mem_rdata),
    .msb         (tx_msb),
    .near_end    (near_end)
  );

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state      <= CMD;
      cnt        <= '0;
      cmd_sr     <= '0;
      addr_sr    <= '0;
      word_addr  <= '0;
      offset     <= '0;
      lat        <= '0;
      id_sr      <= '0;
      ren_q      <= 1'b0;
      pf_pending <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      ren_q      <= 1'b0;
      cmd_err    <= 1'b0;
      pf_pending <= prefetch;
      case (state)
        CMD: begin
          cmd_sr <= cmd_next[6:0];
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(7)) begin
            cnt <= '0;
            if (cmd_next == CMD_READ || cmd_next == CMD_FAST_READ) begin
              state <= ADDR;
              lat   <= lat_of(cmd_next, DUMMY_CYCLES);
            end else if (cmd_next == CMD_RDID) begin
              state <= ID;
              id_sr <= JEDEC_ID;
            end else begin
              state   <= ERR;
              cmd_err <= 1'b1;
            end
          end
        end
        ADDR: begin
          addr_sr <= addr_next[ADDR_BITS-2:0];
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(ADDR_BITS - 1)) begin
            word_addr <= addr_next & WORD_MASK;
            offset    <= addr_next[OFF-1:0];
            ren_q     <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(lat)) begin
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (pf_pending) word_addr <= word_addr + STEP;
        end
        ID: begin
          id_sr <= {id_sr[22:0], id_sr[23]};
        end
        ERR: begin
        end
        default: state <= CMD;
      endcase
    end
  end

  assign mem_ren  = ren_q | prefetch;
  assign mem_addr = prefetch ? (word_addr + STEP) : word_addr;
  assign spi_miso = (state == DATA) ? tx_msb :
                    (state == ID)   ? id_sr[23] : 1'b0;

endmodule

// File: tb/tb_spi_flash_stream.sv
module tb_spi_flash_stream;

  localparam int DB = 8;
  localparam int W  = 64;

  logic        spi_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        miso0, miso1, ren0, ren1, err0, err1;
  logic [23:0] addr0, addr1;
  logic [63:0] rdata0 = '0, rdata1 = '0;

  // dut0: 8 dummy cycles for 0Bh, dut1: 0 dummy cycles (latency clamps to 2)
  spi_flash_stream #(.DUMMY_CYCLES(8)) dut0 (
    .spi_clk(spi_clk), .reset(reset), .spi_mosi(spi_mosi), .spi_miso(miso0),
    .mem_ren(ren0), .mem_addr(addr0), .mem_rdata(rdata0), .cmd_err(err0));
  spi_flash_stream #(.DUMMY_CYCLES(0)) dut1 (
    .spi_clk(spi_clk), .reset(reset), .spi_mosi(spi_mosi), .spi_miso(miso1),
    .mem_ren(ren1), .mem_addr(addr1), .mem_rdata(rdata1), .cmd_err(err1));

  always #5 spi_clk = ~spi_clk;

  int cyc = 0;
  always @(posedge spi_clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Backing store: hashed contents with explicit overrides.
  logic [7:0] mem_ovr[int];

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    int v;
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    v = int'(a) * 29 + (int'(a) >> 8) * 7 + 90;
    return v[7:0];
  endfunction

  function automatic logic [63:0] mem_word(input logic [23:0] a);
    logic [63:0] w;
    for (int i = 0; i < DB; i++) w[8*i +: 8] = mem_byte(a + 24'(i));
    return w;
  endfunction

  always @(posedge spi_clk) begin
    if (ren0) rdata0 <= mem_word(addr0);
    if (ren1) rdata1 <= mem_word(addr1);
  end

  // Scoreboard: expected miso per (cycle, dut), expected strobe and error events.
  typedef struct {int d; int c; logic [23:0] a;} ev_t;
  bit   exp_miso[int];
  ev_t  ren_q[$];
  ev_t  err_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic miso, input logic ren,
                     input logic [23:0] addr, input logic err);
    int c;
    int idx;
    c = cyc + 1;
    if (exp_miso.exists(c*2 + d)) begin
      check($sformatf("miso dut%0d cycle %0d", d, c), 64'(miso), 64'(exp_miso[c*2 + d]));
      exp_miso.delete(c*2 + d);
    end
    if (ren) begin
      idx = -1;
      foreach (ren_q[i]) if (idx < 0 && ren_q[i].d == d) idx = i;
      if (idx < 0) check($sformatf("unexpected mem_ren dut%0d cycle %0d", d, c), 64'(ren), 64'(0));
      else begin
        check($sformatf("mem_ren cycle dut%0d", d), 64'(c), 64'(ren_q[idx].c));
        check($sformatf("mem_addr dut%0d cycle %0d", d, c), 64'(addr), 64'(ren_q[idx].a));
        ren_q.delete(idx);
      end
    end
    if (err) begin
      idx = -1;
      foreach (err_q[i]) if (idx < 0 && err_q[i].d == d) idx = i;
      if (idx < 0) check($sformatf("unexpected cmd_err dut%0d cycle %0d", d, c), 64'(err), 64'(0));
      else begin
        check($sformatf("cmd_err cycle dut%0d", d), 64'(c), 64'(err_q[idx].c));
        err_q.delete(idx);
      end
    end
  endtask

  always @(negedge spi_clk) begin
    mon(0, miso0, ren0, addr0, err0);
    mon(1, miso1, ren1, addr1, err1);
  end

  // Reference model: a read streams bytes a, a+1, ... MSB first starting
  // lat+1 cycles after the last address bit; the word after the current one
  // is fetched while the second-to-last bit of the current word is on the wire.
  task automatic expect_read(input int d, input int k, input logic [23:0] a,
                             input int lat, input int c_last);
    logic [23:0] base, ba;
    logic [7:0]  by;
    int j, p;
    base = a & 24'hFFFFF8;
    ren_q.push_back('{d, k + 1, base});
    for (int c = k + 1; c <= k + lat; c++) exp_miso[c*2 + d] = 1'b0;
    for (int c = k + lat + 1; c <= c_last; c++) begin
      j  = c - (k + lat + 1);
      ba = a + 24'(j / 8);
      by = mem_byte(ba);
      exp_miso[c*2 + d] = by[7 - j % 8];
      p = int'(a[2:0]) * 8 + j;
      if (p % W == W - 2) ren_q.push_back('{d, c, base + 24'((p / W + 1) * DB)});
    end
  endtask

  task automatic expect_id(input int d, input int k8, input int c_last);
    logic [23:0] idv;
    int j;
    idv = 24'hEF4017;
    for (int c = k8 + 1; c <= c_last; c++) begin
      j = c - k8 - 1;
      exp_miso[c*2 + d] = idv[23 - j % 24];
    end
  endtask

  // Called just after a posedge; the bit is sampled at the next posedge.
  task automatic send_bit(input logic b, output int edge_no);
    spi_mosi = b;
    edge_no  = cyc + 1;
    exp_miso[edge_no*2]     = 1'b0;
    exp_miso[edge_no*2 + 1] = 1'b0;
    @(posedge spi_clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("reset miso0", 64'(miso0), 64'(0));
    check("reset miso1", 64'(miso1), 64'(0));
    check("reset mem_ren0", 64'(ren0), 64'(0));
    check("reset mem_ren1", 64'(ren1), 64'(0));
    check("reset mem_addr0", 64'(addr0), 64'(0));
    check("reset mem_addr1", 64'(addr1), 64'(0));
    check("reset cmd_err0", 64'(err0), 64'(0));
    check("reset cmd_err1", 64'(err1), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge spi_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [23:0] a, input int nbits);
    int e, k8, k, c_last, lat0;
    for (int i = 7; i >= 0; i--) send_bit(cmd[i], e);
    k8 = e;
    if (cmd == 8'h03 || cmd == 8'h0B) begin
      for (int i = 23; i >= 0; i--) send_bit(a[i], e);
      k = e;
      lat0 = (cmd == 8'h0B) ? 8 : 2;
      c_last = k + lat0 + nbits;
      expect_read(0, k, a, lat0, c_last);
      expect_read(1, k, a, 2, c_last);
    end else if (cmd == 8'h9F) begin
      c_last = k8 + nbits;
      expect_id(0, k8, c_last);
      expect_id(1, k8, c_last);
    end else begin
      c_last = k8 + 4;
      for (int d = 0; d < 2; d++) begin
        err_q.push_back('{d, k8 + 1, 24'h0});
        for (int c = k8 + 1; c <= c_last; c++) exp_miso[c*2 + d] = 1'b0;
      end
    end
    while (cyc < c_last) begin
      @(posedge spi_clk); #1;
    end
    check($sformatf("miso bits unchecked cmd %0h", cmd), 64'(exp_miso.num()), 64'(0));
    check($sformatf("mem_ren missing cmd %0h", cmd), 64'(ren_q.size()), 64'(0));
    check($sformatf("cmd_err missing cmd %0h", cmd), 64'(err_q.size()), 64'(0));
    exp_miso.delete();
    ren_q.delete();
    err_q.delete();
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rc;
    logic [23:0] ra;
    for (int i = 0; i < 8; i++) mem_ovr[16 + i] = 8'(i + 1);
    reset = 1'b1;
    repeat (2) @(posedge spi_clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    txn(8'h03, 24'h000010, 64);
    txn(8'h03, 24'h000013, 64);
    txn(8'h0B, 24'h000010, 24);
    txn(8'h03, 24'hFFFFF8, 128);
    txn(8'h9F, 24'h000000, 48);
    txn(8'h05, 24'h000000, 0);
    txn(8'h03, 24'h000040, 13);
    txn(8'h03, 24'h000040, 32);
    repeat (6) begin
      rc = ($urandom % 2) ? 8'h03 : 8'h0B;
      ra = 24'($urandom);
      txn(rc, ra, int'($urandom_range(8, 150)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
